// File: rtl/cpu_types_pkg.sv
// Shared types for the multicycle CPU: ISA opcode/funct/ALU encodings,
// control-unit state and mux-select constants.
package cpu_types_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_ALU_R, CLS_JR, CLS_J, CLS_JAL, CLS_BEQ,
        CLS_BNE, CLS_ALU_I, CLS_LUI, CLS_LW, CLS_SW, CLS_HALT
    } instr_class_t;

    localparam logic [5:0] HALT_OPCODE = 6'h3F;

    localparam logic [1:0] PC_NEXT   = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_JR     = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;
    localparam logic [1:0] WD_LUI = 2'd3;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Datapath/memory-side signal bundle of the multicycle control unit.
// master = control unit, slave = datapath and cache side.
interface multicycle_control_unit_if #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
);
    logic [WORD_W-1:0] instr;
    logic              ihit;
    logic              dhit;
    logic              zero;
    logic              iREN;
    logic              dREN;
    logic              dWEN;
    logic              IRWrite;
    logic              PCWrite;
    logic [1:0]        pc_sel;
    logic              RegWrite;
    logic [1:0]        regdst_sel;
    logic [1:0]        wdat_sel;
    logic              ALUsrc;
    logic              ExtOp;
    logic [3:0]        aluop;
    logic [2:0]        state_o;
    logic              illegal;
    logic              halt;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instr_cnt;

    modport master (
        input  instr, ihit, dhit, zero,
        output iREN, dREN, dWEN, IRWrite, PCWrite, pc_sel, RegWrite,
               regdst_sel, wdat_sel, ALUsrc, ExtOp, aluop, state_o,
               illegal, halt, cycle_cnt, instr_cnt
    );

    modport slave (
        output instr, ihit, dhit, zero,
        input  iREN, dREN, dWEN, IRWrite, PCWrite, pc_sel, RegWrite,
               regdst_sel, wdat_sel, ALUsrc, ExtOp, aluop, state_o,
               illegal, halt, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/multicycle_control_unit_decode.sv
// Combinational IR decoder: instruction class plus ALU controls for EXECUTE.
module mcu_decode
    import cpu_types_pkg::*;
#(
    parameter int         WORD_W  = 32,
    parameter logic [5:0] HALT_OP = HALT_OPCODE
) (
    input  logic [WORD_W-1:0] instr,
    output instr_class_t      cls,
    output aluop_t            aluop,
    output logic              alu_src,
    output logic              ext_op,
    output logic              illegal
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign opcode            = instr[WORD_W-1 -: 6];
    assign funct             = instr[5:0];
    assign unused_instr_bits = ^instr[WORD_W-7:6];

    always_comb begin
        cls     = CLS_ILLEGAL;
        aluop   = ALU_ADD;
        alu_src = 1'b0;
        ext_op  = 1'b0;
        // HALT_OP is a parameter, so it is matched ahead of the fixed opcode map
        if (opcode == HALT_OP) begin
            cls = CLS_HALT;
        end else begin
            case (opcode)
                OP_RTYPE: begin
                    cls = CLS_ALU_R;
                    case (funct)
                        FN_SLL:           aluop = ALU_SLL;
                        FN_SRL:           aluop = ALU_SRL;
                        FN_JR:            cls   = CLS_JR;
                        FN_ADD, FN_ADDU:  aluop = ALU_ADD;
                        FN_SUB, FN_SUBU:  aluop = ALU_SUB;
                        FN_AND:           aluop = ALU_AND;
                        FN_OR:            aluop = ALU_OR;
                        FN_XOR:           aluop = ALU_XOR;
                        FN_NOR:           aluop = ALU_NOR;
                        FN_SLT:           aluop = ALU_SLT;
                        FN_SLTU:          aluop = ALU_SLTU;
                        default:          cls   = CLS_ILLEGAL;
                    endcase
                end
                OP_J:     cls = CLS_J;
                OP_JAL:   cls = CLS_JAL;
                OP_BEQ:   begin cls = CLS_BEQ;   aluop = ALU_SUB;  ext_op = 1'b1; end
                OP_BNE:   begin cls = CLS_BNE;   aluop = ALU_SUB;  ext_op = 1'b1; end
                OP_ADDIU: begin cls = CLS_ALU_I; aluop = ALU_ADD;  alu_src = 1'b1; ext_op = 1'b1; end
                OP_SLTI:  begin cls = CLS_ALU_I; aluop = ALU_SLT;  alu_src = 1'b1; ext_op = 1'b1; end
                OP_SLTIU: begin cls = CLS_ALU_I; aluop = ALU_SLTU; alu_src = 1'b1; ext_op = 1'b1; end
                OP_ANDI:  begin cls = CLS_ALU_I; aluop = ALU_AND;  alu_src = 1'b1; end
                OP_ORI:   begin cls = CLS_ALU_I; aluop = ALU_OR;   alu_src = 1'b1; end
                OP_XORI:  begin cls = CLS_ALU_I; aluop = ALU_XOR;  alu_src = 1'b1; end
                OP_LUI:   begin cls = CLS_LUI;   aluop = ALU_ADD;  alu_src = 1'b1; end
                OP_LW:    begin cls = CLS_LW;    aluop = ALU_ADD;  alu_src = 1'b1; ext_op = 1'b1; end
                OP_SW:    begin cls = CLS_SW;    aluop = ALU_ADD;  alu_src = 1'b1; ext_op = 1'b1; end
                default:  cls = CLS_ILLEGAL;
            endcase
        end
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALT with
// ihit/dhit stalls, sticky halt and saturating cycle/retired counters.
module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int         WORD_W  = 32,
    parameter int         CNT_W   = 32,
    parameter logic [5:0] HALT_OP = HALT_OPCODE
) (
    input logic                 CLK,
    input logic                 nRST,
    multicycle_control_unit_if.master bus
);
    state_t           state;
    state_t           state_next;
    instr_class_t     cls;
    aluop_t           dec_aluop;
    logic             dec_alu_src;
    logic             dec_ext_op;
    logic             dec_illegal;
    logic             retire;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instr_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    mcu_decode #(
        .WORD_W  (WORD_W),
        .HALT_OP (HALT_OP)
    ) u_decode (
        .instr   (bus.instr),
        .cls     (cls),
        .aluop   (dec_aluop),
        .alu_src (dec_alu_src),
        .ext_op  (dec_ext_op),
        .illegal (dec_illegal)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_FETCH;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state <= state_next;
            if (state != S_HALT) cycle_cnt_q <= sat_inc(cycle_cnt_q);
            if (retire)          instr_cnt_q <= sat_inc(instr_cnt_q);
        end
    end

    always_comb begin
        state_next     = state;
        retire         = 1'b0;
        bus.iREN       = 1'b0;
        bus.dREN       = 1'b0;
        bus.dWEN       = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.pc_sel     = PC_NEXT;
        bus.RegWrite   = 1'b0;
        bus.regdst_sel = RD_RT;
        bus.wdat_sel   = WD_ALU;
        bus.ALUsrc     = 1'b0;
        bus.ExtOp      = 1'b0;
        bus.aluop      = '0;
        bus.illegal    = 1'b0;
        bus.halt       = 1'b0;
        // Outputs are gated by nRST so an access in flight drops the moment reset asserts
        if (nRST) begin
            case (state)
                S_FETCH: begin
                    bus.iREN = 1'b1;
                    if (bus.ihit) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        state_next  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (cls == CLS_HALT) begin
                        state_next = S_HALT;
                    end else if (dec_illegal) begin
                        bus.illegal = 1'b1;
                        retire      = 1'b1;
                        state_next  = S_FETCH;
                    end else if (cls == CLS_J || cls == CLS_JAL) begin
                        bus.PCWrite = 1'b1;
                        bus.pc_sel  = PC_JUMP;
                        retire      = 1'b1;
                        state_next  = S_FETCH;
                        if (cls == CLS_JAL) begin
                            bus.RegWrite   = 1'b1;
                            bus.regdst_sel = RD_RA;
                            bus.wdat_sel   = WD_PC4;
                        end
                    end else begin
                        state_next = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    bus.aluop  = dec_aluop;
                    bus.ALUsrc = dec_alu_src;
                    bus.ExtOp  = dec_ext_op;
                    case (cls)
                        CLS_BEQ, CLS_BNE: begin
                            bus.PCWrite = (cls == CLS_BEQ) ? bus.zero : ~bus.zero;
                            bus.pc_sel  = PC_BRANCH;
                            retire      = 1'b1;
                            state_next  = S_FETCH;
                        end
                        CLS_JR: begin
                            bus.PCWrite = 1'b1;
                            bus.pc_sel  = PC_JR;
                            retire      = 1'b1;
                            state_next  = S_FETCH;
                        end
                        CLS_LW, CLS_SW: state_next = S_MEMORY;
                        default:        state_next = S_WRITEBACK;
                    endcase
                end
                S_MEMORY: begin
                    if (cls == CLS_SW) begin
                        bus.dWEN = 1'b1;
                        if (bus.dhit) begin
                            retire     = 1'b1;
                            state_next = S_FETCH;
                        end
                    end else begin
                        bus.dREN = 1'b1;
                        if (bus.dhit) state_next = S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    bus.RegWrite   = 1'b1;
                    bus.regdst_sel = (cls == CLS_ALU_R) ? RD_RD : RD_RT;
                    bus.wdat_sel   = (cls == CLS_LW)  ? WD_MEM :
                                     (cls == CLS_LUI) ? WD_LUI : WD_ALU;
                    retire         = 1'b1;
                    state_next     = S_FETCH;
                end
                S_HALT:  bus.halt  = 1'b1;
                default: state_next = S_FETCH;
            endcase
        end
    end

    assign bus.state_o   = state;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: two instances (8- and 4-bit
// counters) share stimulus; a phase-level reference model queues per-cycle expectations.
module tb_multicycle_control_unit;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] instr;
    logic        ihit, dhit, zero;

    always #5 CLK = ~CLK;

    multicycle_control_unit_if #(.WORD_W(32), .CNT_W(8)) bus8 ();
    multicycle_control_unit_if #(.WORD_W(32), .CNT_W(4)) bus4 ();

    assign bus8.instr = instr;
    assign bus8.ihit  = ihit;
    assign bus8.dhit  = dhit;
    assign bus8.zero  = zero;
    assign bus4.instr = instr;
    assign bus4.ihit  = ihit;
    assign bus4.dhit  = dhit;
    assign bus4.zero  = zero;

    multicycle_control_unit #(.WORD_W(32), .CNT_W(8), .HALT_OP(6'h3F)) dut8 (
        .CLK(CLK), .nRST(nRST), .bus(bus8));
    multicycle_control_unit #(.WORD_W(32), .CNT_W(4), .HALT_OP(6'h3F)) dut4 (
        .CLK(CLK), .nRST(nRST), .bus(bus4));

    typedef struct packed {
        logic       iREN, dREN, dWEN, IRWrite, PCWrite;
        logic [1:0] pc_sel;
        logic       RegWrite;
        logic [1:0] regdst_sel, wdat_sel;
        logic       ALUsrc, ExtOp;
        logic [3:0] aluop;
        logic [2:0] state;
        logic       illegal, halt;
    } ctl_t;

    typedef struct {
        ctl_t  ctl;
        int    cyc;
        int    ret;
        string tag;
    } exp_t;

    localparam int K_R = 0, K_JR = 1, K_J = 2, K_JAL = 3, K_BEQ = 4, K_BNE = 5,
                   K_I = 6, K_LUI = 7, K_LW = 8, K_SW = 9, K_HALT = 10, K_ILL = 11;

    exp_t q[$];
    exp_t e;
    ctl_t a8, a4;
    int   checks = 0;
    int   errors = 0;
    int   m_cyc  = 0;
    int   m_ret  = 0;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic ctl_t base(input state_t s);
        ctl_t c = '0;
        c.state = s;
        return c;
    endfunction

    // ISA reference: class and EXECUTE-phase ALU controls of an instruction word
    function automatic void classify(input logic [31:0] w, output int k,
                                     output logic [3:0] op, output logic src, output logic ext);
        logic [5:0] o, f;
        o = w[31:26];
        f = w[5:0];
        k = K_ILL; op = ALU_ADD; src = 1'b0; ext = 1'b0;
        case (o)
            6'h00: begin
                k = K_R;
                case (f)
                    6'h00: op = ALU_SLL;
                    6'h02: op = ALU_SRL;
                    6'h08: k = K_JR;
                    6'h20, 6'h21: op = ALU_ADD;
                    6'h22, 6'h23: op = ALU_SUB;
                    6'h24: op = ALU_AND;
                    6'h25: op = ALU_OR;
                    6'h26: op = ALU_XOR;
                    6'h27: op = ALU_NOR;
                    6'h2A: op = ALU_SLT;
                    6'h2B: op = ALU_SLTU;
                    default: k = K_ILL;
                endcase
            end
            6'h02: k = K_J;
            6'h03: k = K_JAL;
            6'h04: begin k = K_BEQ; op = ALU_SUB; ext = 1'b1; end
            6'h05: begin k = K_BNE; op = ALU_SUB; ext = 1'b1; end
            6'h09: begin k = K_I; op = ALU_ADD;  src = 1'b1; ext = 1'b1; end
            6'h0A: begin k = K_I; op = ALU_SLT;  src = 1'b1; ext = 1'b1; end
            6'h0B: begin k = K_I; op = ALU_SLTU; src = 1'b1; ext = 1'b1; end
            6'h0C: begin k = K_I; op = ALU_AND;  src = 1'b1; end
            6'h0D: begin k = K_I; op = ALU_OR;   src = 1'b1; end
            6'h0E: begin k = K_I; op = ALU_XOR;  src = 1'b1; end
            6'h0F: begin k = K_LUI; op = ALU_ADD; src = 1'b1; end
            6'h23: begin k = K_LW; op = ALU_ADD; src = 1'b1; ext = 1'b1; end
            6'h2B: begin k = K_SW; op = ALU_ADD; src = 1'b1; ext = 1'b1; end
            6'h3F: k = K_HALT;
            default: k = K_ILL;
        endcase
    endfunction

    // One clock of stimulus; the expectation for this cycle enters the scoreboard
    task automatic step(input logic [31:0] w, input logic ih, input logic dh, input logic z,
                        input ctl_t c, input logic retires, input string tag);
        @(posedge CLK); #1;
        nRST = 1'b1;
        instr = w; ihit = ih; dhit = dh; zero = z;
        q.push_back('{c, m_cyc, m_ret, tag});
        if (c.state != S_HALT) m_cyc++;
        if (retires) m_ret++;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            nRST = 1'b0;
            ihit = 1'($urandom); dhit = 1'($urandom); zero = 1'($urandom);
            q.push_back('{ctl_t'('0), 0, 0, "reset"});
        end
        m_cyc = 0;
        m_ret = 0;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic run_instr(input logic [31:0] w, input int iw, input int dw,
                             input logic z, input int abort_mem);
        int         k;
        logic [3:0] op;
        logic       src, ext;
        ctl_t       c;
        logic       hit;
        classify(w, k, op, src, ext);
        for (int i = 0; i < iw; i++) begin
            c = base(S_FETCH); c.iREN = 1'b1;
            step(w, 1'b0, rb(), rb(), c, 1'b0, "fetch_wait");
        end
        c = base(S_FETCH); c.iREN = 1'b1; c.IRWrite = 1'b1; c.PCWrite = 1'b1;
        step(w, 1'b1, rb(), rb(), c, 1'b0, "fetch");
        c = base(S_DECODE);
        if (k == K_HALT) begin
            step(w, rb(), rb(), rb(), c, 1'b0, "decode_halt");
            for (int i = 0; i < 4; i++) begin
                c = base(S_HALT); c.halt = 1'b1;
                step(w, rb(), rb(), rb(), c, 1'b0, "halt");
            end
            do_reset(2);
            return;
        end
        if (k == K_J || k == K_JAL) begin
            c.PCWrite = 1'b1; c.pc_sel = 2'd2;
            if (k == K_JAL) begin c.RegWrite = 1'b1; c.regdst_sel = 2'd2; c.wdat_sel = 2'd2; end
            step(w, rb(), rb(), rb(), c, 1'b1, "decode_jump");
            return;
        end
        if (k == K_ILL) begin
            c.illegal = 1'b1;
            step(w, rb(), rb(), rb(), c, 1'b1, "decode_illegal");
            return;
        end
        step(w, rb(), rb(), rb(), c, 1'b0, "decode");
        c = base(S_EXECUTE); c.aluop = op; c.ALUsrc = src; c.ExtOp = ext;
        if (k == K_BEQ || k == K_BNE || k == K_JR) begin
            c.PCWrite = (k == K_JR) ? 1'b1 : ((k == K_BEQ) ? z : ~z);
            c.pc_sel  = (k == K_JR) ? 2'd3 : 2'd1;
            step(w, rb(), rb(), z, c, 1'b1, "execute_pc");
            return;
        end
        step(w, rb(), rb(), rb(), c, 1'b0, "execute");
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i <= dw; i++) begin
                if (i == abort_mem) begin
                    do_reset(2);
                    return;
                end
                hit = (i == dw);
                c = base(S_MEMORY);
                if (k == K_LW) c.dREN = 1'b1; else c.dWEN = 1'b1;
                step(w, rb(), hit, rb(), c, hit && (k == K_SW), "memory");
            end
            if (k == K_SW) return;
        end
        c = base(S_WRITEBACK); c.RegWrite = 1'b1;
        c.regdst_sel = (k == K_R) ? 2'd1 : 2'd0;
        c.wdat_sel   = (k == K_LW) ? 2'd1 : ((k == K_LUI) ? 2'd3 : 2'd0);
        step(w, rb(), rb(), rb(), c, 1'b1, "writeback");
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  ops [16] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                  6'h09, 6'h0A, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h11, 6'h3F};
        logic [5:0]  fns [14] = '{6'h00, 6'h02, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                                  6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3E};
        logic [31:0] w;
        w = $urandom;
        w[31:26] = ops[$urandom_range(0, 15)];
        if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 13)];
        return w;
    endfunction

    always @(negedge CLK) begin
        if (q.size() > 0) begin
            e  = q.pop_front();
            a8 = {bus8.iREN, bus8.dREN, bus8.dWEN, bus8.IRWrite, bus8.PCWrite, bus8.pc_sel,
                  bus8.RegWrite, bus8.regdst_sel, bus8.wdat_sel, bus8.ALUsrc, bus8.ExtOp,
                  bus8.aluop, bus8.state_o, bus8.illegal, bus8.halt};
            a4 = {bus4.iREN, bus4.dREN, bus4.dWEN, bus4.IRWrite, bus4.PCWrite, bus4.pc_sel,
                  bus4.RegWrite, bus4.regdst_sel, bus4.wdat_sel, bus4.ALUsrc, bus4.ExtOp,
                  bus4.aluop, bus4.state_o, bus4.illegal, bus4.halt};
            checks++;
            if (a8 !== e.ctl) begin
                errors++;
                $display("FAIL ctl8 %s t=%0t: got %h required %h", e.tag, $time, a8, e.ctl);
            end
            checks++;
            if (a4 !== e.ctl) begin
                errors++;
                $display("FAIL ctl4 %s t=%0t: got %h required %h", e.tag, $time, a4, e.ctl);
            end
            checks++;
            if (bus8.cycle_cnt !== 8'(sat(e.cyc, 255)) || bus8.instr_cnt !== 8'(sat(e.ret, 255))) begin
                errors++;
                $display("FAIL cnt8 %s t=%0t: got cyc=%0d ret=%0d required cyc=%0d ret=%0d", e.tag,
                         $time, bus8.cycle_cnt, bus8.instr_cnt, sat(e.cyc, 255), sat(e.ret, 255));
            end
            checks++;
            if (bus4.cycle_cnt !== 4'(sat(e.cyc, 15)) || bus4.instr_cnt !== 4'(sat(e.ret, 15))) begin
                errors++;
                $display("FAIL cnt4 %s t=%0t: got cyc=%0d ret=%0d required cyc=%0d ret=%0d", e.tag,
                         $time, bus4.cycle_cnt, bus4.instr_cnt, sat(e.cyc, 15), sat(e.ret, 15));
            end
        end
    end

    initial begin
        instr = '0; ihit = 1'b0; dhit = 1'b0; zero = 1'b0;
        do_reset(2);
        // Directed: ADDU with two ihit wait cycles, then the main classes
        run_instr(32'h0022_1821, 2, 0, 1'b0, -1);
        run_instr(32'h8C22_0004, 0, 2, 1'b0, -1);
        run_instr(32'hAC22_0004, 1, 2, 1'b0, -1);
        run_instr(32'h1022_0003, 0, 0, 1'b1, -1);
        run_instr(32'h1022_0003, 0, 0, 1'b0, -1);
        run_instr(32'h1422_0003, 0, 0, 1'b1, -1);
        run_instr(32'h1422_0003, 0, 0, 1'b0, -1);
        run_instr(32'h0C00_0010, 0, 0, 1'b0, -1);
        run_instr(32'h0022_183E, 0, 0, 1'b0, -1);
        run_instr(32'h0800_0010, 0, 0, 1'b0, -1);
        run_instr(32'h03E0_0008, 0, 0, 1'b0, -1);
        run_instr(32'h3C01_1234, 0, 0, 1'b0, -1);
        run_instr(32'h3422_1234, 0, 0, 1'b0, -1);
        run_instr(32'hFC00_0000, 0, 0, 1'b0, -1);
        // Reset while a store waits on dhit
        run_instr(32'h0022_1821, 0, 0, 1'b0, -1);
        run_instr(32'hAC22_0004, 0, 5, 1'b0, 2);
        run_instr(32'h8C22_0004, 0, 0, 1'b0, -1);
        for (int i = 0; i < 150; i++)
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), rb(), -1);
        // Counter saturation: 20 then 300 jumps from a clean reset
        do_reset(1);
        for (int i = 0; i < 20; i++) run_instr(32'h0800_0010, 0, 0, 1'b0, -1);
        for (int i = 0; i < 280; i++) run_instr(32'h0800_0010, $urandom_range(0, 1), 0, 1'b0, -1);
        run_instr(32'h0022_1821, 0, 0, 1'b0, -1);
        repeat (2) @(negedge CLK);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multicycle successor to the single-cycle decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and stalls on the ihit/dhit memory handshakes. It generates per-state datapath control and a sticky halt, and keeps saturating cycle and retired-instruction counters. It sits between the multicycle datapath (IR, zero flag, PC mux) and the cache/memory interface.

Parameters:
WORD_W, 32, instruction/word width (opcode at [WORD_W-1 -: 6], funct at [5:0])
CNT_W, 32, width of the performance counters (saturating)
HALT_OP, 6'h3F, opcode that enters the HALT state

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
instr  in  WORD_W  current IR contents from the datapath
ihit  in  1  instruction memory ready (fetch done this cycle)
dhit  in  1  data memory ready (load/store done this cycle)
zero  in  1  ALU zero flag, valid in EXECUTE
iREN  out  1  instruction read request
dREN  out  1  data read request
dWEN  out  1  data write request
IRWrite  out  1  latch instr into IR
PCWrite  out  1  update PC
pc_sel  out  2  0 PC+4, 1 branch target, 2 jump target, 3 rs (jr)
RegWrite  out  1  register file write enable
regdst_sel  out  2  0 rt, 1 rd, 2 $31
wdat_sel  out  2  0 ALU, 1 mem, 2 PC+4, 3 lui
ALUsrc  out  1  0 reg, 1 extended immediate
ExtOp  out  1  1 sign-extend, 0 zero-extend
aluop  out  4  aluop_t
state_o  out  3  current state (debug)
illegal  out  1  one-cycle pulse on an undecodable opcode/funct
halt  out  1  sticky halt
cycle_cnt  out  CNT_W  cycles since reset, saturating, frozen in HALT
instr_cnt  out  CNT_W  instructions retired, saturating

Behaviour:
- Reset (nRST low, async): state=FETCH. All outputs 0, counters 0. Reset asserted mid-memory-wait aborts the access with no write.
- Control outputs are combinational from state, IR and ihit/dhit. State and counters are registered.
- FETCH: iREN=1. If ihit: IRWrite=1, PCWrite=1, pc_sel=0, next state DECODE. Otherwise hold FETCH, no other writes.
- DECODE:
  - opcode==HALT_OP: go to HALT.
  - J: PCWrite, pc_sel=2, retire, go to FETCH.
  - JAL: as J, plus RegWrite, regdst_sel=2, wdat_sel=2.
  - Unknown opcode or R-type funct: illegal=1, retire as NOP, go to FETCH.
  - Otherwise go to EXECUTE.
- EXECUTE: aluop/ALUsrc/ExtOp driven from IR.
  - BEQ: PCWrite=zero, pc_sel=1, retire, go to FETCH. BNE: PCWrite=~zero, otherwise identical.
  - JR: PCWrite, pc_sel=3, retire, go to FETCH.
  - LW/SW: go to MEMORY.
  - Other R-type and I-type ALU ops: go to WRITEBACK.
- MEMORY:
  - LW: dREN=1 until dhit, then go to WRITEBACK.
  - SW: dWEN=1 until dhit, then retire and go to FETCH.
  - dREN and dWEN are never both 1.
- WRITEBACK: RegWrite=1. regdst_sel=1 for R-type, else 0. wdat_sel=1 for LW, 3 for LUI, else 0. Retire, go to FETCH.
- HALT: halt=1. All enables 0. Absorbing until nRST.
- Retire = instr_cnt+1 at the clock edge (saturates at all-ones). HALT is not counted.
- cycle_cnt increments every non-HALT cycle and saturates at all-ones.
- Minimum latencies with 0-wait memory: J=2, BEQ=3, ALU=4, SW=4, LW=5 cycles.
- ihit asserted outside FETCH and dhit asserted outside MEMORY are ignored.

Decomposition:
- The state enum, pc_sel/regdst_sel/wdat_sel encodings, and opcode/funct constants go in cpu_types_pkg, beside aluop_t, opcode_t and funct_t.
- One sub-module, mcu_decode: purely combinational IR → {class, aluop, ALUsrc, ExtOp, illegal}.
- The FSM and counters stay in the top module.

Test Plan:
- Reset: nRST low then high with ihit=0 → state FETCH, iREN=1, all other outputs 0, counters 0; they stay 0 while ihit=0 (cycle_cnt excepted).
- ADDU with ihit 2 cycles late → 3 FETCH cycles, then DECODE, EXECUTE, WRITEBACK with RegWrite=1, regdst_sel=1. instr_cnt=1, cycle_cnt=6.
- LW, dhit after 3 cycles → dREN high exactly 3 cycles, then WRITEBACK with wdat_sel=1, 7 cycles total. SW with the same dhit timing → dWEN 3 cycles, no RegWrite.
- BEQ with zero=1 → PCWrite=1 and pc_sel=1 in EXECUTE. zero=0 → PCWrite=0. BNE gives the inverse.
- JAL → RegWrite, regdst_sel=2, wdat_sel=2, pc_sel=2 in DECODE. Opcode 6'h3F → halt=1 sticky, counters frozen. An illegal funct raises a single-cycle illegal pulse and increments instr_cnt.
- Reset mid-op: nRST low during a MEMORY wait → dWEN drops immediately and the block restarts in FETCH. CNT_W=4: 20 instructions → instr_cnt=15 (saturated).
